adrv9001_rx_packetizer: RTL and testbench
=========================================

Name: adrv9001_rx_packetizer

Overview:
- Downstream stage of the ADRV9001 receive channel, in the divided data-clock domain.
- Consumes the valid-only 32-bit IQ stream (I in [31:16], Q in [15:0]) and buffers it in a small FIFO.
- Emits a flow-controlled AXI-Stream with tlast every pkt_len samples for DMA capture.
- Input has no backpressure, so FIFO-full samples are dropped and counted.

Parameters:
- DATA_WIDTH, 32, IQ sample width.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4.
- PKT_LEN_WIDTH, 16, width of pkt_len and the sample counter.

Ports:
- clk  input  1  divided data clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- enable  input  1  level; start/continue packet capture
- pkt_len  input  PKT_LEN_WIDTH  samples per packet; sampled at each packet start
- s_axis_tdata  input  DATA_WIDTH  IQ sample
- s_axis_tvalid  input  1  sample valid; no tready
- m_axis_tdata  output  DATA_WIDTH  FIFO head data
- m_axis_tvalid  output  1  FIFO not empty
- m_axis_tready  input  1  downstream accept
- m_axis_tlast  output  1  head sample is last of its packet
- overflow  output  1  sticky drop flag
- overflow_clr  input  1  clears overflow flag and overflow_cnt
- overflow_cnt  output  32  dropped-sample count, saturating at 0xFFFFFFFF
- busy  output  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (rstn=0, async): FIFO emptied, pointers 0, state IDLE, sample counter 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0, overflow_cnt=0, busy=0.
- FIFO stores {last, data}.
  - Write: accepted when not full, or when full and a read (tvalid & tready) occurs in the same cycle.
  - Read: on tvalid & tready; head presented combinationally from storage at rd_ptr.
  - Latency: a sample written in cycle N is visible on m_axis_tvalid in cycle N+1.
  - Output tdata/tlast are held stable while tvalid=1 and tready=0.
- State machine:
  - IDLE: input ignored (not counted as overflow). If enable=1 and pkt_len!=0: latch pkt_len, counter=0, go RUN. pkt_len=0 keeps the block in IDLE.
  - RUN: on each s_axis_tvalid, write the sample if accepted. last = (counter == latched_len-1).
    - Accepted and last: counter=0, relatch pkt_len. If enable=0, go IDLE; else stay in RUN.
    - Accepted and not last: counter+1.
  - RUN, enable falling mid-packet: no new state; keep capturing until the current packet's last sample is accepted, then IDLE. Packets are never truncated.
- Overflow (RUN, s_axis_tvalid=1, write not accepted):
  - Sample dropped; counter does not advance, so every packet still carries exactly latched_len samples.
  - overflow set; overflow_cnt increments (saturating).
- overflow_clr: clears the flag and the count. If a drop occurs in the same cycle, the drop wins: overflow=1, overflow_cnt=1.
- pkt_len changes mid-packet: no effect until the next packet start.
- pkt_len=1: every sample has tlast=1.
- Output drain continues in IDLE until the FIFO is empty; busy falls in the cycle after the final read.

Optional Feature:
- Macro ADRV9001_RX_PKT_TEST_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, the written data is replaced by {ramp[15:0], ~ramp[15:0]}.
  - The 16-bit ramp resets to 0 on IDLE->RUN and increments per accepted write only, so ramp gaps never appear on output.
  - Overflow and tlast rules are unchanged.
- Undefined: port absent; data passes unmodified.

Test Plan:
- Basic packets: reset, pkt_len=4, enable=1, 8 consecutive valid samples 0x00010001..0x00080008, tready=1 -> 8 output beats in order, tlast on beats 4 and 8, first tvalid one cycle after first write, overflow_cnt=0.
- Backpressure and overflow: FIFO_DEPTH=16, pkt_len=8, tready=0, 20 valid samples -> 16 stored, overflow=1, overflow_cnt=4. Then tready=1 -> 16 beats, tlast on beats 8 and 16.
- Graceful stop: pkt_len=10, drop enable after sample 3 -> capture continues to sample 10 (tlast), state IDLE, later valid samples ignored with overflow_cnt unchanged, busy=0 after the last read.
- Full-boundary simultaneity: FIFO full, tready=1 and s_axis_tvalid=1 in the same cycle -> write accepted, no overflow increment, occupancy stays 16.
- Edge lengths: pkt_len=0 with enable=1 -> stays IDLE, no output. pkt_len=1 -> every beat has tlast=1. Change pkt_len 4->2 mid-packet -> current packet 4, next 2.
- Reset and clear: assert rstn low with 5 entries buffered -> tvalid=0 immediately and all outputs at reset values. Pulse overflow_clr coincident with a drop -> overflow=1, overflow_cnt=1. With ADRV9001_RX_PKT_TEST_EN and test_mode=1 -> outputs 0x0000FFFF, 0x0001FFFE, ...

Source files
------------

// File: rtl/adrv9001_rx_packetizer.sv
// rtl/adrv9001_rx_packetizer.sv - ADRV9001 RX IQ stream to AXI-Stream packetizer with drop counting
// Optional test ramp data source enabled by ADRV9001_RX_PKT_TEST_EN.
module adrv9001_rx_packetizer #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int PKT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
`ifdef ADRV9001_RX_PKT_TEST_EN
    input  logic                     test_mode,
`endif
    input  logic                     enable,
    input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [31:0]              overflow_cnt,
    output logic                     busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr, r_rd_ptr;
    state_t                 r_state;
    logic [PKT_LEN_WIDTH-1:0] r_len, r_cnt;
    logic                   r_overflow;
    logic [31:0]            r_ovf_cnt;

    logic [AW:0]            w_count;
    logic                   w_empty, w_full, w_rd, w_wr_req, w_wr, w_drop, w_last;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [DATA_WIDTH:0]    w_head;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_rd     = !w_empty && m_axis_tready;
    assign w_wr_req = (r_state == S_RUN) && s_axis_tvalid;
    // A full FIFO can still take a sample when the head leaves in the same cycle.
    assign w_wr     = w_wr_req && (!w_full || w_rd);
    assign w_drop   = w_wr_req && !w_wr;
    assign w_last   = (r_cnt == r_len - 1'b1);

`ifdef ADRV9001_RX_PKT_TEST_EN
    logic [15:0] r_ramp;

    assign w_wdata = test_mode ? DATA_WIDTH'({r_ramp, ~r_ramp}) : s_axis_tdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ramp <= '0;
        end else if (r_state == S_IDLE) begin
            r_ramp <= '0;
        end else if (w_wr) begin
            r_ramp <= r_ramp + 16'd1;
        end
    end
`else
    assign w_wdata = s_axis_tdata;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_last, w_wdata};
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !w_empty && w_head[DATA_WIDTH];
    assign m_axis_tvalid = !w_empty;
    assign overflow      = r_overflow;
    assign overflow_cnt  = r_ovf_cnt;
    assign busy          = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (enable && (pkt_len != '0)) begin
                        r_state <= S_RUN;
                        r_len   <= pkt_len;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    // Dropped samples do not advance the count, so packets keep full length.
                    if (w_wr) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            r_len <= pkt_len;
                            if (!enable) r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (overflow_clr)               r_ovf_cnt <= 32'd1;
                else if (r_ovf_cnt != '1)       r_ovf_cnt <= r_ovf_cnt + 32'd1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
                r_ovf_cnt  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adrv9001_rx_packetizer.sv
// tb/tb_adrv9001_rx_packetizer.sv - scoreboard bench for adrv9001_rx_packetizer
module tb_adrv9001_rx_packetizer;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic [DW-1:0] din = '0;
    logic          vld = 1'b0;
    logic          rdy = 1'b0;
    logic          clr = 1'b0;
`ifdef ADRV9001_RX_PKT_TEST_EN
    logic          test_mode = 1'b0;
`endif
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, ovf, busy;
    logic [31:0]   ovf_cnt;

    always #5 clk = ~clk;

    adrv9001_rx_packetizer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PKT_LEN_WIDTH(LW)) dut (
        .clk(clk),
        .rstn(rstn),
`ifdef ADRV9001_RX_PKT_TEST_EN
        .test_mode(test_mode),
`endif
        .enable(enable),
        .pkt_len(pkt_len),
        .s_axis_tdata(din),
        .s_axis_tvalid(vld),
        .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(rdy),
        .m_axis_tlast(m_tlast),
        .overflow(ovf),
        .overflow_clr(clr),
        .overflow_cnt(ovf_cnt),
        .busy(busy)
    );

    // Reference model: packet capture state, FIFO occupancy and expected beats.
    int            checks = 0;
    int            errors = 0;
    int            occ = 0;
    bit            m_run = 0;
    int            m_cnt = 0;
    int            m_len = 0;
    bit            m_ovf = 0;
    logic [31:0]   m_ocnt = '0;
    logic [15:0]   m_ramp = '0;
    logic [DW:0]   sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        occ = 0; m_run = 0; m_cnt = 0; m_len = 0;
        m_ovf = 0; m_ocnt = '0; m_ramp = '0;
        sb.delete();
    endtask

    task automatic model_edge();
        bit rd, dropped;
        logic [DW-1:0] d;
        if (!rstn) begin
            reset_model();
            return;
        end
        rd = rdy && (occ > 0);
        dropped = 0;
        if (m_run) begin
            if (vld) begin
                if (occ < DEPTH || rd) begin
                    d = din;
`ifdef ADRV9001_RX_PKT_TEST_EN
                    if (test_mode) d = {m_ramp, ~m_ramp};
`endif
                    sb.push_back({m_cnt == m_len - 1, d});
                    occ++;
                    m_ramp++;
                    if (m_cnt == m_len - 1) begin
                        m_cnt = 0;
                        m_len = int'(pkt_len);
                        if (!enable) m_run = 0;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    dropped = 1;
                    m_ovf = 1;
                    if (clr) m_ocnt = 32'd1;
                    else if (m_ocnt != 32'hFFFF_FFFF) m_ocnt = m_ocnt + 32'd1;
                end
            end
        end else if (enable && pkt_len != 0) begin
            m_run = 1; m_cnt = 0; m_len = int'(pkt_len); m_ramp = '0;
        end
        if (clr && !dropped) begin
            m_ovf = 0; m_ocnt = '0;
        end
        if (rd) occ--;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; vld = 1'b0; enable = 1'b0; clr = 1'b0;
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_busy", busy, 0);
        reset_model();
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic send(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            din = base + DW'(i) * 32'h0001_0001;
            tick();
        end
        vld = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the model on the falling edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rstn) begin
            check("tvalid", m_tvalid, occ > 0);
            check("busy", busy, m_run || occ > 0);
            check("overflow", ovf, m_ovf);
            check("overflow_cnt", ovf_cnt, m_ocnt);
            if (m_tvalid && rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("tdata", m_tdata, e[DW-1:0]);
                    check("tlast", m_tlast, e[DW]);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Basic two packets of 4.
        pkt_len = 16'd4; enable = 1'b1; rdy = 1'b1;
        tick();
        send(8, 32'h0001_0001);
        for (int i = 0; i < 4; i++) tick();
        check("basic_drained", sb.size(), 0);
        check("basic_ovf_cnt", ovf_cnt, 0);

        // Backpressure, overflow, clear-with-drop and full-boundary write.
        do_reset();
        pkt_len = 16'd8; enable = 1'b1; rdy = 1'b0;
        tick();
        send(20, 32'h0100_0100);
        check("ovf_flag", ovf, 1);
        check("ovf_cnt_4", ovf_cnt, 4);
        vld = 1'b1; clr = 1'b1; din = 32'hDEAD_BEEF;
        tick();
        clr = 1'b0; vld = 1'b0;
        check("clr_drop_flag", ovf, 1);
        check("clr_drop_cnt", ovf_cnt, 1);
        rdy = 1'b1; vld = 1'b1; din = 32'h5555_AAAA;
        tick();
        vld = 1'b0;
        check("full_simul_cnt", ovf_cnt, 1);
        for (int i = 0; i < 20; i++) tick();
        check("ovf_drained", sb.size(), 0);

        // Graceful stop mid-packet.
        do_reset();
        pkt_len = 16'd10; enable = 1'b1; rdy = 1'b1;
        tick();
        send(3, 32'h0200_0200);
        enable = 1'b0;
        send(7, 32'h0300_0300);
        send(5, 32'h0400_0400);
        for (int i = 0; i < 4; i++) tick();
        check("stop_busy", busy, 0);
        check("stop_ovf_cnt", ovf_cnt, 0);

        // pkt_len=0 holds IDLE; then pkt_len=1; then 4 -> 2 mid-packet.
        do_reset();
        pkt_len = 16'd0; enable = 1'b1; rdy = 1'b1;
        send(5, 32'h0500_0500);
        check("len0_busy", busy, 0);
        check("len0_tvalid", m_tvalid, 0);
        pkt_len = 16'd1;
        tick();
        send(6, 32'h0600_0600);
        pkt_len = 16'd4;
        send(2, 32'h0700_0700);
        pkt_len = 16'd2;
        send(8, 32'h0800_0800);
        for (int i = 0; i < 4; i++) tick();

        // Async reset with 5 buffered entries.
        rdy = 1'b0;
        send(5, 32'h0900_0900);
        do_reset();

`ifdef ADRV9001_RX_PKT_TEST_EN
        test_mode = 1'b1; pkt_len = 16'd4; enable = 1'b1; rdy = 1'b1;
        tick();
        send(6, 32'h0);
        test_mode = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
`endif

        // Randomized traffic.
        pkt_len = 16'd3;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) pkt_len = LW'($urandom_range(1, 6));
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            clr = ($urandom_range(0, 49) == 0);
            din = $urandom;
`ifdef ADRV9001_RX_PKT_TEST_EN
            test_mode = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end

        // Finish the open packet, then drain.
        enable = 1'b0; clr = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 200 && m_run; i++) begin
            vld = 1'b1; din = $urandom;
            tick();
        end
        vld = 1'b0;
        for (int i = 0; i < 64 && occ > 0; i++) tick();
        tick();
        check("final_busy", busy, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
